// File: rtl/single_port_sync_ram.sv
// Single-port byte-enabled sync RAM that zero-fills itself after reset (busy high during fill).
// Define SPRAM_OUTREG_EN to add a second output register stage (2-cycle read latency).

module spram_lane #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);
  logic [7:0] mem [2**ADDR_W];

  // Storage is deliberately not reset; the owner's clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (wr) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

module single_port_sync_ram #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_vld,
  output logic                busy
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e                          state_q, state_d;
  logic [ADDR_W:0]                 clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]               dout_q, dout_d;
  logic                            dout_vld_q, dout_vld_d;
  logic [ADDR_W-1:0]               mem_addr;
  logic [NUM_LANES-1:0]            lane_wr;
  logic [NUM_LANES-1:0][7:0]       wdata, rd_old, rd_new, din_l;

  assign din_l = din;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      spram_lane #(.ADDR_W(ADDR_W)) u_lane (
        .clk   (clk),
        .wr    (lane_wr[i]),
        .addr  (mem_addr),
        .wdata (wdata[i]),
        .rdata (rd_old[i])
      );
      // Merged post-write view of this lane, used for write-first reads.
      assign rd_new[i] = (we && be[i]) ? din_l[i] : rd_old[i];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    mem_addr   = addr;
    wdata      = din_l;
    lane_wr    = '0;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    case (state_q)
      CLEAR: begin
        mem_addr  = clr_cnt_q[ADDR_W-1:0];
        wdata     = '0;
        lane_wr   = '1;
        clr_cnt_d = clr_cnt_q + (ADDR_W + 1)'(1);
        if (clr_cnt_q == CLR_LAST) state_d = READY;
      end
      READY: begin
        if (en) begin
          if (we) lane_wr = be;
          dout_vld_d = 1'b1;
          dout_d     = (RDW_MODE != 0) ? rd_new : rd_old;
        end
      end
      default: state_d = CLEAR;
    endcase
    // Writes are blocked while reset is held so an aborted access never lands.
    lane_wr = lane_wr & {NUM_LANES{rst_n}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign busy = (state_q == CLEAR);

`ifdef SPRAM_OUTREG_EN
  logic [DATA_W-1:0] dout2_q, dout2_d;
  logic              dout_vld2_q, dout_vld2_d;

  always_comb begin
    dout_vld2_d = dout_vld_q;
    dout2_d     = dout_vld_q ? dout_q : dout2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout2_q     <= '0;
      dout_vld2_q <= 1'b0;
    end else begin
      dout2_q     <= dout2_d;
      dout_vld2_q <= dout_vld2_d;
    end
  end

  assign dout     = dout2_q;
  assign dout_vld = dout_vld2_q;
`else
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
`endif
endmodule
